sf_camera_capture_ctrl: RTL and testbench
=========================================

Name: sf_camera_capture_ctrl

Overview:
Sequencer that owns the camera reader datapath for multi-frame captures.
- Pulses the camera reset, waits for the camera clock generator to lock, then arms the reader for N frames.
- Drains each reader read-FIFO block into a memory-side streaming port.
- Reports frame and word counts, plus done and error status, to the wishbone register slave.
- Sits between the wishbone slave registers and the camera top level (reader, clock generator, flash mux).

Parameters:
- RESET_CYCLES, 1000, cycles the camera reset is held asserted at the start of a capture.
- TIMEOUT_CYCLES, 24'hFFFFFF, watchdog limit for the lock, capture and drain waits (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle capture request from registers.
- i_abort  in  1  one-cycle abort request.
- i_frame_count  in  8  frames per capture; 0 means ignore i_start.
- i_flash_en  in  1  request flash during capture.
- o_busy  out  1  high when not IDLE.
- o_done  out  1  one-cycle pulse at capture completion.
- o_error  out  1  sticky timeout flag, cleared by i_start.
- o_frames_done  out  8  frames completed in the current capture.
- o_word_count  out  32  words forwarded in the current capture.
- o_camera_reset  out  1  to camera reset input.
- o_enable  out  1  reader enable.
- o_reset_counts  out  1  one-cycle reader count clear.
- o_flash_req  out  1  manual flash request.
- i_clk_locked  in  1  clock generator lock.
- i_captured  in  1  reader frame-captured level.
- i_inactive  in  1  reader idle.
- i_rfifo_ready  in  1  reader block available.
- o_rfifo_activate  out  1  claim reader block.
- o_rfifo_strobe  out  1  one pop per cycle.
- i_rfifo_data  in  32  reader data.
- i_rfifo_size  in  24  words in the claimed block.
- o_mem_data  out  32  memory-side data.
- o_mem_valid  out  1  memory-side word valid.
- i_mem_ready  in  1  memory side can accept a word.

Behaviour:
- Reset values: o_camera_reset=1; all other outputs 0; state IDLE; all counters 0.
- Main FSM states: IDLE, CAM_RST, WAIT_LOCK, ARM, CAPTURE, DRAIN, DONE.
- IDLE: o_camera_reset=1. On i_start with i_frame_count!=0: clear o_frames_done, o_word_count and o_error; latch the frame count; go to CAM_RST.
- CAM_RST: o_camera_reset=1 for exactly RESET_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: o_camera_reset=0. Go to ARM on the first cycle i_clk_locked=1.
- ARM: o_reset_counts=1 for one cycle; next cycle go to CAPTURE.
- CAPTURE: o_enable=1 and o_flash_req=i_flash_en. On an i_captured rising edge (registered compare), drop o_enable and go to DRAIN.
- DRAIN: wait until i_rfifo_ready=0, the drain sub-FSM is idle, and i_inactive=1. Then increment o_frames_done. If it now equals the latched count, go to DONE; otherwise go to ARM (no camera re-reset).
- DONE: o_done=1 for one cycle, then IDLE.
- Drain sub-FSM (runs in CAPTURE and DRAIN): D_IDLE, D_ACTIVE.
  - D_IDLE: on i_rfifo_ready and o_rfifo_activate=0, assert activate next cycle and latch i_rfifo_size into a 24-bit remaining counter.
  - D_ACTIVE: o_rfifo_strobe = i_mem_ready && remaining!=0. o_mem_valid=o_rfifo_strobe and o_mem_data=i_rfifo_data in the same cycle (combinational, zero latency). Each strobe decrements remaining and increments o_word_count (32-bit, wraps).
  - When remaining==0, deassert activate next cycle and return to D_IDLE. A latched size of 0 therefore releases after one active cycle.
  - Never strobe when activate=0.
- i_abort in any non-IDLE state: next cycle o_enable=0, o_rfifo_activate=0, o_flash_req=0, state IDLE. o_done is not pulsed and counts are preserved. i_abort takes priority over a simultaneous i_start.
- i_start while busy is ignored.
- Asserting rst mid-operation forces the reset values immediately, including o_camera_reset=1.

Optional Feature:
- Macro: SF_CAMERA_CTRL_TIMEOUT_EN.
- With the macro: a 24-bit watchdog clears on every state change and on every strobe. It counts in WAIT_LOCK, CAPTURE and DRAIN. On reaching TIMEOUT_CYCLES it sets o_error=1 and performs the abort sequence.
- Without the macro: no watchdog logic; o_error is tied 0; these states wait indefinitely.

Decomposition:
- Shared package sf_camera_ctrl_pkg holds:
  - the main and drain state encodings;
  - the width constants FRAME_W=8, SIZE_W=24, WORD_CNT_W=32.
- One natural sub-module, sf_camera_rfifo_drain: the drain sub-FSM with its remaining counter, activate/strobe logic and the word counter increment output.

Test Plan:
- i_frame_count=1, lock 5 cycles after reset release, one block of size 16 with i_mem_ready=1 -> o_camera_reset high exactly RESET_CYCLES, 16 strobes, o_word_count=16, o_frames_done=1, single o_done pulse.
- i_frame_count=3, two blocks of 8 per frame -> three ARM pulses of o_reset_counts, a single camera reset, o_word_count=48, o_done once.
- i_mem_ready toggling 1/0 each cycle during a size-10 block -> exactly 10 strobes, none while i_mem_ready=0, activate drops the cycle after the 10th strobe.
- Block with i_rfifo_size=0 -> activate high one cycle, zero strobes, o_word_count unchanged.
- i_abort mid-CAPTURE, one cycle before an i_start -> IDLE next cycle, o_enable=0, activate=0, no o_done, i_start ignored.
- With SF_CAMERA_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, i_clk_locked held 0 -> o_error=1 after 100 WAIT_LOCK cycles, state IDLE; next i_start clears o_error.

Source files
------------

// File: rtl/sf_camera_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sf_camera_ctrl_pkg
// Purpose : Shared widths and state encodings for the camera capture
//           sequencer and its reader-FIFO drain sub-block.
// Contents: FRAME_W / SIZE_W / WORD_CNT_W / DATA_W width constants,
//           main_state_t (capture sequencer), drain_state_t (drain FSM).
// Revision: 1.0 - initial release
// ============================================================================
package sf_camera_ctrl_pkg;

  localparam int unsigned FRAME_W    = 8;
  localparam int unsigned SIZE_W     = 24;
  localparam int unsigned WORD_CNT_W = 32;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAM_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ARM       = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_DONE      = 3'd6
  } main_state_t;

  typedef enum logic [0:0] {
    D_IDLE   = 1'b0,
    D_ACTIVE = 1'b1
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/sf_camera_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sf_camera_capture_ctrl_if
// Purpose : Groups the reader read-FIFO block handshake and the memory-side
//           streaming port of the capture sequencer.
// Ports   : i_rfifo_ready / i_rfifo_size / i_rfifo_data  - reader block side
//           o_rfifo_activate / o_rfifo_strobe           - block claim / pop
//           o_mem_data / o_mem_valid / i_mem_ready       - memory stream
// Modports: master = capture controller, slave = reader + memory side.
// Revision: 1.0 - initial release
// ============================================================================
interface sf_camera_capture_ctrl_if;
  import sf_camera_ctrl_pkg::*;

  logic                  i_rfifo_ready;
  logic [SIZE_W-1:0]     i_rfifo_size;
  logic [DATA_W-1:0]     i_rfifo_data;
  logic                  o_rfifo_activate;
  logic                  o_rfifo_strobe;
  logic [DATA_W-1:0]     o_mem_data;
  logic                  o_mem_valid;
  logic                  i_mem_ready;

  modport master (
    input  i_rfifo_ready, i_rfifo_size, i_rfifo_data, i_mem_ready,
    output o_rfifo_activate, o_rfifo_strobe, o_mem_data, o_mem_valid
  );

  modport slave (
    output i_rfifo_ready, i_rfifo_size, i_rfifo_data, i_mem_ready,
    input  o_rfifo_activate, o_rfifo_strobe, o_mem_data, o_mem_valid
  );

endinterface
`default_nettype wire

// File: rtl/sf_camera_capture_ctrl_drain.sv
`default_nettype none
// ============================================================================
// Module  : sf_camera_rfifo_drain
// Purpose : Claims one reader read-FIFO block at a time and forwards its words
//           to the memory stream, one pop per accepted cycle.
// Ports   : clk, rst (async, active-low)
//           run            - claiming of new blocks allowed
//           flush          - drop any claimed block next cycle
//           rfifo_ready/size/data, mem_ready  - upstream/downstream inputs
//           rfifo_activate/strobe, mem_data/valid - handshake outputs
//           word_inc       - one word forwarded this cycle
//           idle           - no block claimed
// Revision: 1.0 - initial release
// ============================================================================
module sf_camera_rfifo_drain
  import sf_camera_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              flush,
  input  logic              rfifo_ready,
  input  logic [SIZE_W-1:0] rfifo_size,
  input  logic [DATA_W-1:0] rfifo_data,
  input  logic              mem_ready,
  output logic              rfifo_activate,
  output logic              rfifo_strobe,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_valid,
  output logic              word_inc,
  output logic              idle
);

  drain_state_t      state;
  logic [SIZE_W-1:0] remaining;

  // Pop is combinational so the memory side sees the word in the same cycle
  // the reader presents it; gating on activate keeps it silent when unclaimed.
  assign rfifo_strobe = rfifo_activate && (state == D_ACTIVE) && mem_ready &&
                        (remaining != '0);
  assign mem_valid    = rfifo_strobe;
  assign mem_data     = rfifo_data;
  assign word_inc     = rfifo_strobe;
  assign idle         = (state == D_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= D_IDLE;
      remaining      <= '0;
      rfifo_activate <= 1'b0;
    end else if (flush) begin
      state          <= D_IDLE;
      remaining      <= '0;
      rfifo_activate <= 1'b0;
    end else begin
      case (state)
        D_IDLE: begin
          if (run && rfifo_ready && !rfifo_activate) begin
            rfifo_activate <= 1'b1;
            remaining      <= rfifo_size;
            state          <= D_ACTIVE;
          end
        end
        D_ACTIVE: begin
          // Release is taken one cycle after remaining is seen at zero, so a
          // zero-sized block still holds activate for exactly one cycle.
          if (remaining == '0) begin
            rfifo_activate <= 1'b0;
            state          <= D_IDLE;
          end else if (rfifo_strobe) begin
            remaining <= remaining - SIZE_W'(1);
          end
        end
        default: begin
          state          <= D_IDLE;
          rfifo_activate <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sf_camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sf_camera_capture_ctrl
// Purpose : Multi-frame capture sequencer. Pulses the camera reset, waits for
//           the camera clock lock, arms the reader per frame, drains reader
//           blocks to the memory stream and reports status to the registers.
// Ports   : clk, rst (async, active-low)
//           i_start/i_abort/i_frame_count/i_flash_en - register requests
//           o_busy/o_done/o_error/o_frames_done/o_word_count - status
//           o_camera_reset/o_enable/o_reset_counts/o_flash_req - camera ctrl
//           i_clk_locked/i_captured/i_inactive - camera / reader status
//           bus (master) - reader FIFO block handshake and memory stream
// Options : SF_CAMERA_CTRL_TIMEOUT_EN - adds a TIMEOUT_CYCLES watchdog on the
//           lock, capture and drain waits that sets o_error and aborts.
// Revision: 1.0 - initial release
// ============================================================================
module sf_camera_capture_ctrl
  import sf_camera_ctrl_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES   = 1000,
  parameter logic [SIZE_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [FRAME_W-1:0]    i_frame_count,
  input  logic                  i_flash_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [FRAME_W-1:0]    o_frames_done,
  output logic [WORD_CNT_W-1:0] o_word_count,
  output logic                  o_camera_reset,
  output logic                  o_enable,
  output logic                  o_reset_counts,
  output logic                  o_flash_req,
  input  logic                  i_clk_locked,
  input  logic                  i_captured,
  input  logic                  i_inactive,
  sf_camera_capture_ctrl_if.master bus
);

  main_state_t          state;
  logic [31:0]          rst_cnt;
  logic [FRAME_W-1:0]   frames_target;
  logic [FRAME_W-1:0]   frames_next;
  logic                 captured_q;
  logic                 captured_rise;
  logic                 drain_run;
  logic                 drain_flush;
  logic                 drain_idle;
  logic                 word_inc;
  logic                 timeout_hit;
  logic                 abort_now;

  assign o_busy        = (state != ST_IDLE);
  assign frames_next   = o_frames_done + FRAME_W'(1);
  assign captured_rise = i_captured && !captured_q;
  assign abort_now     = o_busy && (i_abort || timeout_hit);
  assign drain_run     = (state == ST_CAPTURE) || (state == ST_DRAIN);
  assign drain_flush   = abort_now;

`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
  logic              err;
  logic [SIZE_W-1:0] wd;
  logic [SIZE_W-1:0] wd_eff;
  logic              wd_counting;
  main_state_t       prev_state;

  // A state change is seen one cycle late through prev_state, so the entry
  // cycle is treated as count 0 and the stored count is re-seeded to 1.
  assign wd_counting = (state == ST_WAIT_LOCK) || (state == ST_CAPTURE) ||
                       (state == ST_DRAIN);
  assign wd_eff      = (state == prev_state) ? wd : '0;
  assign timeout_hit = wd_counting && (wd_eff == TIMEOUT_CYCLES - SIZE_W'(1));
  assign o_error     = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd         <= '0;
      prev_state <= ST_IDLE;
    end else begin
      prev_state <= state;
      if (!wd_counting || bus.o_rfifo_strobe) begin
        wd <= '0;
      end else begin
        wd <= wd_eff + SIZE_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign o_error               = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      rst_cnt        <= '0;
      frames_target  <= '0;
      o_frames_done  <= '0;
      o_word_count   <= '0;
      o_camera_reset <= 1'b1;
      o_enable       <= 1'b0;
      o_reset_counts <= 1'b0;
      o_flash_req    <= 1'b0;
      o_done         <= 1'b0;
      captured_q     <= 1'b0;
`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
      err            <= 1'b0;
`endif
    end else begin
      captured_q     <= i_captured;
      o_reset_counts <= 1'b0;
      o_done         <= 1'b0;
      if (word_inc) begin
        o_word_count <= o_word_count + WORD_CNT_W'(1);
      end

      if (abort_now) begin
        // Counts are kept for the registers; only the camera side is parked.
        state          <= ST_IDLE;
        o_camera_reset <= 1'b1;
        o_enable       <= 1'b0;
        o_flash_req    <= 1'b0;
`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
        if (timeout_hit) begin
          err <= 1'b1;
        end
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            o_camera_reset <= 1'b1;
            if (i_start && !i_abort && (i_frame_count != '0)) begin
              o_frames_done <= '0;
              o_word_count  <= '0;
              frames_target <= i_frame_count;
              rst_cnt       <= '0;
              state         <= ST_CAM_RST;
`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
              err           <= 1'b0;
`endif
            end
          end
          ST_CAM_RST: begin
            if (rst_cnt == RESET_CYCLES - 32'd1) begin
              o_camera_reset <= 1'b0;
              state          <= ST_WAIT_LOCK;
            end else begin
              rst_cnt <= rst_cnt + 32'd1;
            end
          end
          ST_WAIT_LOCK: begin
            if (i_clk_locked) begin
              o_reset_counts <= 1'b1;
              state          <= ST_ARM;
            end
          end
          ST_ARM: begin
            o_enable    <= 1'b1;
            o_flash_req <= i_flash_en;
            state       <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            if (captured_rise) begin
              o_enable    <= 1'b0;
              o_flash_req <= 1'b0;
              state       <= ST_DRAIN;
            end else begin
              o_flash_req <= i_flash_en;
            end
          end
          ST_DRAIN: begin
            if (!bus.i_rfifo_ready && drain_idle && i_inactive) begin
              o_frames_done <= frames_next;
              if (frames_next == frames_target) begin
                o_done <= 1'b1;
                state  <= ST_DONE;
              end else begin
                // Next frame re-arms the reader without re-resetting the camera.
                o_reset_counts <= 1'b1;
                state          <= ST_ARM;
              end
            end
          end
          ST_DONE: begin
            o_camera_reset <= 1'b1;
            state          <= ST_IDLE;
          end
          default: begin
            o_camera_reset <= 1'b1;
            o_enable       <= 1'b0;
            o_flash_req    <= 1'b0;
            state          <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sf_camera_rfifo_drain u_drain (
    .clk            (clk),
    .rst            (rst),
    .run            (drain_run),
    .flush          (drain_flush),
    .rfifo_ready    (bus.i_rfifo_ready),
    .rfifo_size     (bus.i_rfifo_size),
    .rfifo_data     (bus.i_rfifo_data),
    .mem_ready      (bus.i_mem_ready),
    .rfifo_activate (bus.o_rfifo_activate),
    .rfifo_strobe   (bus.o_rfifo_strobe),
    .mem_data       (bus.o_mem_data),
    .mem_valid      (bus.o_mem_valid),
    .word_inc       (word_inc),
    .idle           (drain_idle)
  );

endmodule
`default_nettype wire

// File: tb/tb_sf_camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sf_camera_capture_ctrl
// Purpose : Directed self-checking bench for sf_camera_capture_ctrl with a
//           short camera reset (20 cycles) and a 100-cycle watchdog limit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sf_camera_capture_ctrl;

  localparam int RST_CYC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_flash_en;
  logic [7:0]  i_frame_count;
  logic        o_busy, o_done, o_error;
  logic [7:0]  o_frames_done;
  logic [31:0] o_word_count;
  logic        o_camera_reset, o_enable, o_reset_counts, o_flash_req;
  logic        i_clk_locked, i_captured, i_inactive;

  int errors = 0;
  int checks = 0;

  sf_camera_capture_ctrl_if bus ();

  sf_camera_capture_ctrl #(
    .RESET_CYCLES   (RST_CYC),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_frame_count  (i_frame_count),
    .i_flash_en     (i_flash_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_frames_done  (o_frames_done),
    .o_word_count   (o_word_count),
    .o_camera_reset (o_camera_reset),
    .o_enable       (o_enable),
    .o_reset_counts (o_reset_counts),
    .o_flash_req    (o_flash_req),
    .i_clk_locked   (i_clk_locked),
    .i_captured     (i_captured),
    .i_inactive     (i_inactive),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge (pre-update values).
  int n_strobe = 0, n_bad = 0, n_data_bad = 0, n_done = 0, n_arm = 0;
  int n_cam_fall = 0, n_cam_busy = 0, n_act_high = 0, n_flash = 0;
  int cyc = 0, last_strobe_cyc = 0, act_fall_cyc = 0;
  bit prev_act = 1'b0, prev_cam = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (bus.o_rfifo_strobe) begin
      n_strobe++;
      last_strobe_cyc = cyc;
    end
    if (bus.o_rfifo_strobe && (!bus.i_mem_ready || !bus.o_rfifo_activate)) n_bad++;
    if (bus.o_mem_valid !== bus.o_rfifo_strobe) n_bad++;
    if (bus.o_mem_valid && (bus.o_mem_data !== bus.i_rfifo_data)) n_data_bad++;
    if (o_done) n_done++;
    if (o_reset_counts) n_arm++;
    if (prev_cam && !o_camera_reset) n_cam_fall++;
    if (o_camera_reset && o_busy) n_cam_busy++;
    if (bus.o_rfifo_activate) n_act_high++;
    if (o_flash_req && o_enable) n_flash++;
    if (prev_act && !bus.o_rfifo_activate) act_fall_cyc = cyc;
    prev_act = bus.o_rfifo_activate;
    prev_cam = o_camera_reset;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic start_capture(input int frames, input bit flash);
    i_start = 1'b1; i_frame_count = 8'(frames); i_flash_en = flash;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_enable(output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (o_camera_reset && n < 100) begin @(negedge clk); n++; end
    if (o_camera_reset) ok = 1'b0;
    if (!i_clk_locked) begin
      repeat (5) @(negedge clk);
      i_clk_locked = 1'b1;
    end
    n = 0;
    while (!o_enable && n < 100) begin @(negedge clk); n++; end
    if (!o_enable) ok = 1'b0;
    i_inactive = 1'b0;
  endtask

  task automatic serve_block(input int size, input bit toggle, output bit ok);
    int n;
    ok = 1'b1;
    bus.i_rfifo_size  = 24'(size);
    bus.i_rfifo_ready = 1'b1;
    n = 0;
    while (!bus.o_rfifo_activate && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_rfifo_activate) ok = 1'b0;
    bus.i_rfifo_ready = 1'b0;
    n = 0;
    while (bus.o_rfifo_activate && n < 300) begin
      bus.i_rfifo_data = $urandom;
      @(negedge clk);
      if (toggle) bus.i_mem_ready = ~bus.i_mem_ready;
      n++;
    end
    if (bus.o_rfifo_activate) ok = 1'b0;
    bus.i_mem_ready = 1'b1;
  endtask

  task automatic finish_frame(input int ndrain, input int size, output bit ok);
    bit bok;
    ok = 1'b1;
    i_captured = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_captured = 1'b0;
    for (int b = 0; b < ndrain; b++) begin
      serve_block(size, 1'b0, bok);
      ok &= bok;
    end
    i_inactive = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (o_busy && n < 200) begin @(negedge clk); n++; end
    ok = !o_busy;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    checks++; if (o_camera_reset !== 1'b1) begin errors++; $display("FAIL reset_cam_rst: got %b expected 1", o_camera_reset); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if ({o_done, o_error, o_enable, o_reset_counts, o_flash_req} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {o_done, o_error, o_enable, o_reset_counts, o_flash_req}); end
    checks++; if (o_frames_done !== 8'd0 || o_word_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", o_frames_done, o_word_count); end
    checks++; if ({bus.o_rfifo_activate, bus.o_rfifo_strobe, bus.o_mem_valid} !== 3'b0) begin errors++; $display("FAIL reset_bus: got %b expected 000", {bus.o_rfifo_activate, bus.o_rfifo_strobe, bus.o_mem_valid}); end
  endtask

  task automatic test_single_frame;
    bit ok1, ok2, ok3, ok4;
    int s_str, s_done, s_arm, s_cam, s_fl, s_bad, s_dat;
    s_str = n_strobe; s_done = n_done; s_arm = n_arm; s_cam = n_cam_busy;
    s_fl = n_flash; s_bad = n_bad; s_dat = n_data_bad;
    start_capture(1, 1'b1);
    wait_enable(ok1);
    start_capture(3, 1'b1);  // busy: must be ignored
    serve_block(16, 1'b0, ok2);
    finish_frame(0, 0, ok3);
    wait_idle(ok4);
    i_clk_locked = 1'b0;
    checks++; if (!(ok1 && ok2 && ok3 && ok4)) begin errors++; $display("FAIL single_progress: got %b%b%b%b expected 1111", ok1, ok2, ok3, ok4); end
    checks++; if (n_cam_busy - s_cam != RST_CYC) begin errors++; $display("FAIL single_cam_reset_len: got %0d expected %0d", n_cam_busy - s_cam, RST_CYC); end
    checks++; if (n_strobe - s_str != 16) begin errors++; $display("FAIL single_strobes: got %0d expected 16", n_strobe - s_str); end
    checks++; if (o_word_count !== 32'd16) begin errors++; $display("FAIL single_word_count: got %0d expected 16", o_word_count); end
    checks++; if (o_frames_done !== 8'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", o_frames_done); end
    checks++; if (n_done - s_done != 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", n_done - s_done); end
    checks++; if (n_arm - s_arm != 1) begin errors++; $display("FAIL single_arm: got %0d expected 1", n_arm - s_arm); end
    checks++; if (n_flash - s_fl == 0) begin errors++; $display("FAIL single_flash: got %0d expected >0", n_flash - s_fl); end
    checks++; if (n_bad != s_bad || n_data_bad != s_dat) begin errors++; $display("FAIL single_stream: got %0d/%0d bad expected 0/0", n_bad - s_bad, n_data_bad - s_dat); end
    checks++; if (o_error !== 1'b0 || o_camera_reset !== 1'b1) begin errors++; $display("FAIL single_idle_state: got err=%b cam=%b expected 0 1", o_error, o_camera_reset); end
  endtask

  task automatic test_multi_frame;
    bit ok, okf;
    int s_done, s_arm, s_fall, s_fl;
    s_done = n_done; s_arm = n_arm; s_fall = n_cam_fall; s_fl = n_flash;
    ok = 1'b1;
    start_capture(3, 1'b0);
    for (int f = 0; f < 3; f++) begin
      wait_enable(okf); ok &= okf;
      serve_block(8, 1'b0, okf); ok &= okf;   // during CAPTURE
      finish_frame(1, 8, okf); ok &= okf;     // second block during DRAIN
    end
    wait_idle(okf); ok &= okf;
    i_clk_locked = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL multi_progress: got 0 expected 1"); end
    checks++; if (n_arm - s_arm != 3) begin errors++; $display("FAIL multi_arm_pulses: got %0d expected 3", n_arm - s_arm); end
    checks++; if (n_cam_fall - s_fall != 1) begin errors++; $display("FAIL multi_cam_resets: got %0d expected 1", n_cam_fall - s_fall); end
    checks++; if (o_word_count !== 32'd48) begin errors++; $display("FAIL multi_word_count: got %0d expected 48", o_word_count); end
    checks++; if (o_frames_done !== 8'd3) begin errors++; $display("FAIL multi_frames: got %0d expected 3", o_frames_done); end
    checks++; if (n_done - s_done != 1) begin errors++; $display("FAIL multi_done_pulses: got %0d expected 1", n_done - s_done); end
    checks++; if (n_flash != s_fl) begin errors++; $display("FAIL multi_no_flash: got %0d expected 0", n_flash - s_fl); end
  endtask

  task automatic test_backpressure;
    bit ok1, ok2, ok3, ok4;
    int s_str, s_bad;
    s_str = n_strobe; s_bad = n_bad;
    start_capture(1, 1'b0);
    wait_enable(ok1);
    bus.i_mem_ready = 1'b1;
    serve_block(10, 1'b1, ok2);
    finish_frame(0, 0, ok3);
    wait_idle(ok4);
    i_clk_locked = 1'b0;
    checks++; if (!(ok1 && ok2 && ok3 && ok4)) begin errors++; $display("FAIL bp_progress: got %b%b%b%b expected 1111", ok1, ok2, ok3, ok4); end
    checks++; if (n_strobe - s_str != 10) begin errors++; $display("FAIL bp_strobes: got %0d expected 10", n_strobe - s_str); end
    checks++; if (n_bad != s_bad) begin errors++; $display("FAIL bp_gated_strobe: got %0d bad expected 0", n_bad - s_bad); end
    // Last strobe, one cycle with remaining at zero, then activate is low.
    checks++; if (act_fall_cyc - last_strobe_cyc != 2) begin errors++; $display("FAIL bp_release_timing: got %0d expected 2", act_fall_cyc - last_strobe_cyc); end
    checks++; if (o_word_count !== 32'd10) begin errors++; $display("FAIL bp_word_count: got %0d expected 10", o_word_count); end
  endtask

  task automatic test_zero_size;
    bit ok1, ok2, ok3, ok4, ok5;
    int s_act, s_str;
    start_capture(1, 1'b0);
    wait_enable(ok1);
    serve_block(5, 1'b0, ok2);
    s_act = n_act_high; s_str = n_strobe;
    serve_block(0, 1'b0, ok3);
    checks++; if (n_act_high - s_act != 1) begin errors++; $display("FAIL zero_activate_cycles: got %0d expected 1", n_act_high - s_act); end
    checks++; if (n_strobe != s_str) begin errors++; $display("FAIL zero_strobes: got %0d expected 0", n_strobe - s_str); end
    checks++; if (o_word_count !== 32'd5) begin errors++; $display("FAIL zero_word_count: got %0d expected 5", o_word_count); end
    finish_frame(0, 0, ok4);
    wait_idle(ok5);
    i_clk_locked = 1'b0;
    checks++; if (!(ok1 && ok2 && ok3 && ok4 && ok5)) begin errors++; $display("FAIL zero_progress: got %b%b%b%b%b expected 11111", ok1, ok2, ok3, ok4, ok5); end
  endtask

  task automatic test_abort;
    bit ok1, ok2;
    int n, s_done;
    s_done = n_done;
    start_capture(2, 1'b1);
    wait_enable(ok1);
    serve_block(4, 1'b0, ok2);
    // Hold a large block claimed with the memory side stalled.
    bus.i_mem_ready = 1'b0; bus.i_rfifo_size = 24'd50; bus.i_rfifo_ready = 1'b1;
    n = 0;
    while (!bus.o_rfifo_activate && n < 50) begin @(negedge clk); n++; end
    bus.i_rfifo_ready = 1'b0;
    checks++; if (!(ok1 && ok2 && bus.o_rfifo_activate && o_enable && o_flash_req)) begin errors++; $display("FAIL abort_setup: got %b%b%b%b%b expected 11111", ok1, ok2, bus.o_rfifo_activate, o_enable, o_flash_req); end
    i_abort = 1'b1;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b expected 0", o_busy); end
    checks++; if (o_enable !== 1'b0 || bus.o_rfifo_activate !== 1'b0 || o_flash_req !== 1'b0) begin errors++; $display("FAIL abort_outputs: got %b%b%b expected 000", o_enable, bus.o_rfifo_activate, o_flash_req); end
    // Abort still held while a start arrives: abort wins.
    i_start = 1'b1; i_frame_count = 8'd1;
    @(negedge clk);
    i_abort = 1'b0; i_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored: got busy=%b expected 0", o_busy); end
    checks++; if (n_done != s_done) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", n_done - s_done); end
    checks++; if (o_word_count !== 32'd4 || o_frames_done !== 8'd0) begin errors++; $display("FAIL abort_counts_kept: got %0d/%0d expected 4/0", o_word_count, o_frames_done); end
    bus.i_mem_ready = 1'b1; i_inactive = 1'b1; i_clk_locked = 1'b0;
  endtask

  task automatic test_async_reset;
    bit ok;
    start_capture(1, 1'b1);
    wait_enable(ok);
    #2 rst = 1'b0;
    #1;
    checks++; if (!ok || o_camera_reset !== 1'b1 || o_enable !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL async_reset: got ok=%b cam=%b en=%b busy=%b expected 1 1 0 0", ok, o_camera_reset, o_enable, o_busy); end
    checks++; if (o_word_count !== 32'd0 || o_flash_req !== 1'b0) begin errors++; $display("FAIL async_reset_regs: got %0d/%b expected 0/0", o_word_count, o_flash_req); end
    @(negedge clk);
    rst = 1'b1; i_clk_locked = 1'b0; i_inactive = 1'b1;
    @(negedge clk);
  endtask

`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    i_clk_locked = 1'b0;
    start_capture(1, 1'b0);
    n = 0;
    while (o_camera_reset && n < 100) begin @(negedge clk); n++; end
    checks++; if (o_camera_reset !== 1'b0) begin errors++; $display("FAIL to_reach_lock: got cam=%b expected 0", o_camera_reset); end
    repeat (99) @(negedge clk);
    checks++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL to_early: got err=%b busy=%b expected 0 1", o_error, o_busy); end
    @(negedge clk);
    checks++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL to_fire: got err=%b busy=%b expected 1 0", o_error, o_busy); end
    start_capture(1, 1'b0);
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL to_clear_on_start: got %b expected 0", o_error); end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_flash_en = 1'b0; i_frame_count = 8'd0;
    i_clk_locked = 1'b0; i_captured = 1'b0; i_inactive = 1'b1;
    bus.i_rfifo_ready = 1'b0; bus.i_rfifo_size = 24'd0;
    bus.i_rfifo_data = 32'd0; bus.i_mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_single_frame();
    test_multi_frame();
    test_backpressure();
    test_zero_size();
    test_abort();
    test_async_reset();
`ifdef SF_CAMERA_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
